// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bundle of requester, RAM and status signals around the memory port arbiter
interface mem_port_arbiter_if #(
  parameter int WORD_W = 32
);
  // data side (coherence bus controller)
  logic                   dREN;
  logic                   dWEN;
  logic [WORD_W-1:0]      daddr;
  logic [WORD_W-1:0]      dstore;
  logic [WORD_W-1:0]      dload;
  logic                   dwait;
  // instruction side (one requester per core)
  logic [1:0]             iREN;
  logic [1:0][WORD_W-1:0] iaddr;
  logic [1:0][WORD_W-1:0] iload;
  logic [1:0]             iwait;
  // RAM side
  logic                   ramREN;
  logic                   ramWEN;
  logic [WORD_W-1:0]      ramaddr;
  logic [WORD_W-1:0]      ramstore;
  logic [WORD_W-1:0]      ramload;
  logic [1:0]             ramstate;
  // sticky status
  logic                   err;
  logic                   timeout;

  // arbiter view
  modport slave (
    input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    output dload, dwait, iload, iwait, ramREN, ramWEN, ramaddr, ramstore, err, timeout
  );

  // environment view: requesters plus the RAM model
  modport master (
    output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    input  dload, dwait, iload, iwait, ramREN, ramWEN, ramaddr, ramstore, err, timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-grant RAM port arbiter: data priority, round-robin ifetch, watchdog
module mem_port_arbiter #(
  parameter int WORD_W      = 32,
  parameter int MAX_WAIT    = 15,
  parameter int DATA_STREAK = 4
) (
  input  logic                CLK,
  input  logic                RST,
  mem_port_arbiter_if.slave   bus
);

  localparam int WD_W = $clog2(MAX_WAIT + 1);
  localparam int SK_W = $clog2(DATA_STREAK + 1);

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            rr_q, rr_d;
  logic            g_q, g_d;
  logic [SK_W-1:0] streak_q, streak_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            err_q, err_d;
  logic            timeout_q, timeout_d;

  logic            any_d;
  logic            any_i;
  logic            done;
  logic            is_err;
  logic [WD_W-1:0] wdog_inc;

  assign any_d    = bus.dREN | bus.dWEN;
  assign any_i    = |bus.iREN;
  // ACCESS and ERROR both end a transfer; FREE and BUSY keep it open
  assign done     = bus.ramstate[1];
  assign is_err   = (bus.ramstate == RAM_ERROR);
  assign wdog_inc = wdog_q + 1'b1;

  assign bus.err     = err_q;
  assign bus.timeout = timeout_q;

  // Arbitration, grant tracking and RAM/requester muxing (waits pulse in the completion cycle)
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    g_d          = g_q;
    streak_d     = streak_q;
    wdog_d       = wdog_q;
    err_d        = err_q;
    timeout_d    = timeout_q;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.dload    = '0;
    bus.iload    = '0;
    bus.dwait    = 1'b1;
    bus.iwait    = 2'b11;

    case (state_q)
      IDLE: begin
        wdog_d = '0;
        // data wins unless it has used up its streak while a fetch is waiting
        if (any_d && !((streak_q == SK_W'(DATA_STREAK)) && any_i)) begin
          state_d = GNT_D;
        end else if (any_i) begin
          state_d = GNT_I;
          g_d     = bus.iREN[rr_q] ? rr_q : ~rr_q;
        end
      end

      GNT_D: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.dload    = bus.ramload;
        if (bus.dWEN) begin
          bus.ramWEN = 1'b1;
        end else begin
          bus.ramREN = 1'b1;
        end
        if (!any_d) begin
          state_d = IDLE;
        end else if (done) begin
          bus.dwait = 1'b0;
          state_d   = IDLE;
          if (is_err) begin
            err_d = 1'b1;
          end
          if (any_i) begin
            streak_d = (streak_q == SK_W'(DATA_STREAK)) ? streak_q : streak_q + 1'b1;
          end else begin
            streak_d = '0;
          end
        end else begin
          wdog_d = wdog_inc;
          if (wdog_inc == WD_W'(MAX_WAIT)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      GNT_I: begin
        bus.ramREN        = 1'b1;
        bus.ramaddr       = bus.iaddr[g_q];
        bus.iload[g_q]    = bus.ramload;
        if (!bus.iREN[g_q]) begin
          state_d = IDLE;
        end else if (done) begin
          bus.iwait[g_q] = 1'b0;
          state_d        = IDLE;
          rr_d           = ~g_q;
          streak_d       = '0;
          if (is_err) begin
            err_d = 1'b1;
          end
        end else begin
          wdog_d = wdog_inc;
          if (wdog_inc == WD_W'(MAX_WAIT)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and bookkeeping registers; reset forces IDLE so RAM enables drop at once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      g_q       <= 1'b0;
      streak_q  <= '0;
      wdog_q    <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      g_q       <= g_d;
      streak_q  <= streak_d;
      wdog_q    <= wdog_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

endmodule
